muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the execute stage of the MIPS core. It launches when the ALU decoder's `alucontrol` selects MULT, MULTU, DIV or DIVU, then runs a latency-configurable multiplier or a 32-iteration radix-2 divider. It holds the execute stage stalled until the 64-bit result is ready, then issues exactly one HI/LO write. A pipeline flush aborts it cleanly.

---
 rtl/muldiv_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage; issues one HI/LO write per launch.
// Latency: multiply MUL_LAT+1 cycles to DONE, divide 33 cycles, divide-by-zero 1 cycle.
// Backpressure: holds stall_e while computing; waits in DONE while stall_ext is high; flush aborts at once.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   alucontrol_e         execute-stage ALU control; only the four mul/div codes launch
//   src_a, src_b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   stall_ext, flush     other stall source holding E; exception flush of E (highest priority)
//   stall_e              hold request for the execute stage
//   hilo_we              single-cycle HI/LO write strobe
//   hi_out, lo_out       product[63:32]/remainder, product[31:0]/quotient
//   busy                 sequencer is not idle
module muldiv_ctrl #(
  parameter int         WIDTH         = 32,
  parameter int         MUL_LAT       = 2,
  // Default encodings; override with the core's configs.vh values at integration.
  parameter logic [4:0] MULT_CONTROL  = 5'd16,
  parameter logic [4:0] MULTU_CONTROL = 5'd17,
  parameter logic [4:0] DIV_CONTROL   = 5'd18,
  parameter logic [4:0] DIVU_CONTROL  = 5'd19
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       alucontrol_e,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             stall_e,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       cnt;
  // opa/opb hold raw operands for a multiply, magnitudes for a divide.
  // During a divide opa doubles as the dividend/quotient shift register.
  logic [WIDTH-1:0] opa, opb, rem;
  logic             mul_signed, neg_q, neg_r;

  // Operation decode
  logic is_mult, is_multu, is_div, is_divu, is_mul_op, is_div_op, op_valid;
  logic launch, div_zero;

  assign is_mult   = (alucontrol_e == MULT_CONTROL);
  assign is_multu  = (alucontrol_e == MULTU_CONTROL);
  assign is_div    = (alucontrol_e == DIV_CONTROL);
  assign is_divu   = (alucontrol_e == DIVU_CONTROL);
  assign is_mul_op = is_mult | is_multu;
  assign is_div_op = is_div | is_divu;
  assign op_valid  = is_mul_op | is_div_op;
  // resetn is included so stall_e reads 0 while reset is held, even with a valid op on the bus.
  assign launch    = resetn & (state == S_IDLE) & op_valid & ~flush;
  assign div_zero  = is_div_op & (src_b == '0);

  // Magnitudes for the signed divide; unsigned divide uses the raw operands.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (is_div & src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b = (is_div & src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply: sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
  // product are correct for both signed and unsigned operands.
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  assign mul_a_ext = {{WIDTH{mul_signed & opa[WIDTH-1]}}, opa};
  assign mul_b_ext = {{WIDTH{mul_signed & opb[WIDTH-1]}}, opb};
  assign product   = mul_a_ext * mul_b_ext;

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and keep the difference only if it did not go negative.
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_step, quo_step;
  assign rem_sh   = {rem, opa[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opb};
  assign rem_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {opa[WIDTH-2:0], ~diff[WIDTH]};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            if (div_zero)       state_nxt = S_DONE;
            else if (is_div_op) state_nxt = S_DIV;
            else                state_nxt = S_MUL;
          end
        end
        S_MUL:   if (cnt == '0) state_nxt = S_DONE;
        S_DIV:   if (cnt == '0) state_nxt = S_DONE;
        S_DONE:  if (!stall_ext) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall_e = 1'b0;
    hilo_we = 1'b0;
    busy    = (state != S_IDLE);
    if (!flush) begin
      case (state)
        S_IDLE:  stall_e = launch;
        S_MUL:   stall_e = 1'b1;
        S_DIV:   stall_e = 1'b1;
        S_DONE:  hilo_we = ~stall_ext;
        default: stall_e = 1'b0;
      endcase
    end
  end

  // Datapath: operand latch, iteration counter, result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      opa        <= '0;
      opb        <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi_out     <= '0;
      lo_out     <= '0;
    end else if (flush) begin
      // Abort: results are left untouched.
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            mul_signed <= is_mult;
            neg_q      <= is_div & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r      <= is_div & src_a[WIDTH-1];
            rem        <= '0;
            if (div_zero) begin
              cnt    <= '0;
              hi_out <= src_a;
              lo_out <= '1;
            end else if (is_div_op) begin
              cnt <= 5'(WIDTH - 1);
              opa <= mag_a;
              opb <= mag_b;
            end else begin
              cnt <= 5'(MUL_LAT - 1);
              opa <= src_a;
              opb <= src_b;
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            hi_out <= product[2*WIDTH-1:WIDTH];
            lo_out <= product[WIDTH-1:0];
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          opa <= quo_step;
          rem <= rem_step;
          if (cnt == '0) begin
            // Last iteration: apply the sign fix-up (flags are 0 for DIVU).
            lo_out <= neg_q ? -quo_step : quo_step;
            hi_out <= neg_r ? -rem_step : rem_step;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam int         LAT      = 2;
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;

  logic        clk;
  logic        resetn;
  logic [4:0]  alucontrol_e;
  logic [31:0] src_a, src_b;
  logic        stall_ext, flush;
  logic        stall_e, hilo_we, busy;
  logic [31:0] hi_out, lo_out;

  int checks   = 0;
  int failures = 0;

  muldiv_ctrl #(.WIDTH(32), .MUL_LAT(LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alucontrol_e (alucontrol_e),
    .src_a        (src_a),
    .src_b        (src_b),
    .stall_ext    (stall_ext),
    .flush        (flush),
    .stall_e      (stall_e),
    .hilo_we      (hilo_we),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition.
  function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    res = '0;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = sa * sb;
      end
      OP_MULTU: begin
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = ua * ub;
      end
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return 1;
    if (op == OP_DIV || op == OP_DIVU) return 33;
    return LAT + 1;
  endfunction

  // Launch one op in the current cycle, hold it in E until its write commits,
  // then retire it and watch one extra cycle for a stray second pulse.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int stalls, output int wes, output int done_k);
    alucontrol_e = op;
    src_a = a;
    src_b = b;
    stalls = 0;
    wes = 0;
    done_k = -1;
    hi = '0;
    lo = '0;
    for (int k = 0; k < 100 && wes == 0; k++) begin
      @(negedge clk);
      if (stall_e) stalls++;
      if (hilo_we) begin
        wes++;
        hi = hi_out;
        lo = lo_out;
        done_k = k;
      end
      @(posedge clk);
      #1;
      // Operands on the bus change after launch; the result must not.
      src_a = $urandom;
      src_b = $urandom;
    end
    alucontrol_e = OP_NOP;
    @(negedge clk);
    if (hilo_we) wes++;
    if (stall_e) stalls++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rhi, rlo, phi, plo, ra, rb;
    logic [4:0]  rop;
    logic [63:0] exp64;
    int          st, we, dk;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
    vecs[1] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3};
    vecs[2] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 3};
    vecs[3] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 3};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[6] = '{OP_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1};
    vecs[7] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[8] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};

    resetn = 1'b0;
    alucontrol_e = OP_NOP;
    src_a = '0;
    src_b = '0;
    stall_ext = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall_e", 64'(stall_e), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_hi",      64'(hi_out),  64'd0);
    check("rst_lo",      64'(lo_out),  64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, st, we, dk);
      check($sformatf("vec%0d_hi", i),     64'(rhi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i),     64'(rlo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_stall", i),  64'(st),  64'(vecs[i].lat));
      check($sformatf("vec%0d_done", i),   64'(dk),  64'(vecs[i].lat));
      check($sformatf("vec%0d_pulses", i), 64'(we),  64'd1);
    end

    // Flush during DIVU at t0+10, then a MULT at t0+12
    phi = hi_out;
    plo = lo_out;
    alucontrol_e = OP_DIVU;
    src_a = 32'd1000;
    src_b = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) check("flush_pre_stall", 64'(stall_e), 64'd1);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_e", 64'(stall_e), 64'd0);
    check("flush_hilo_we", 64'(hilo_we), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    alucontrol_e = OP_NOP;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy),    64'd0);
    check("flush_idle_we",   64'(hilo_we), 64'd0);
    check("flush_hold_hi",   64'(hi_out),  64'(phi));
    check("flush_hold_lo",   64'(lo_out),  64'(plo));
    @(posedge clk);
    #1;
    run_op(OP_MULT, 32'hFFFF_FFF0, 32'h0000_1234, rhi, rlo, st, we, dk);
    check("flush_mult_res", {rhi, rlo}, ref_model(OP_MULT, 32'hFFFF_FFF0, 32'h0000_1234));
    check("flush_mult_pulses", 64'(we), 64'd1);

    // MULTU held in DONE by stall_ext for 4 cycles
    alucontrol_e = OP_MULTU;
    src_a = 32'h0001_0000;
    src_b = 32'h0003_0001;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    stall_ext = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("hold%0d_busy", j),  64'(busy),    64'd1);
      check($sformatf("hold%0d_we", j),    64'(hilo_we), 64'd0);
      check($sformatf("hold%0d_stall", j), 64'(stall_e), 64'd0);
      @(posedge clk);
      #1;
    end
    stall_ext = 1'b0;
    @(negedge clk);
    check("hold_release_we", 64'(hilo_we), 64'd1);
    check("hold_result", {hi_out, lo_out}, ref_model(OP_MULTU, 32'h0001_0000, 32'h0003_0001));
    @(posedge clk);
    #1;
    // Back-to-back: next op launches the cycle after the commit.
    run_op(OP_DIVU, 32'd12345, 32'd100, rhi, rlo, st, we, dk);
    check("b2b_res",   {rhi, rlo}, 64'({32'd45, 32'd123}));
    check("b2b_stall", 64'(st), 64'd33);
    check("b2b_pulse", 64'(we), 64'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = OP_MULT;
        1:       rop = OP_MULTU;
        2:       rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
      case ($urandom_range(0, 7))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      exp64 = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, rhi, rlo, st, we, dk);
      check($sformatf("rand%0d_res", i),    {rhi, rlo}, exp64);
      check($sformatf("rand%0d_stall", i),  64'(st), 64'(exp_lat(rop, rb)));
      check($sformatf("rand%0d_done", i),   64'(dk), 64'(exp_lat(rop, rb)));
      check($sformatf("rand%0d_pulses", i), 64'(we), 64'd1);
    end

    // Reset asserted mid-DIV: outputs return to zero immediately
    alucontrol_e = OP_DIV;
    src_a = 32'h7654_3210;
    src_b = 32'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("midrst_stall_e", 64'(stall_e), 64'd0);
    check("midrst_hilo_we", 64'(hilo_we), 64'd0);
    check("midrst_busy",    64'(busy),    64'd0);
    check("midrst_hi",      64'(hi_out),  64'd0);
    check("midrst_lo",      64'(lo_out),  64'd0);
    @(posedge clk);
    #1;
    alucontrol_e = OP_NOP;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd7, rhi, rlo, st, we, dk);
    check("post_rst_res", {rhi, rlo}, ref_model(OP_DIV, 32'hFFFF_FF00, 32'd7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
